// File: rtl/inst_fifo_pkg.sv
// inst_fifo_pkg: shared entry type, default depth and pointer-width helper for inst_fifo.
//   fifo_entry_t  : pc[31:0], inst[31:0], except[7:0] (packed, pc in the MSBs)
//   DEFAULT_DEPTH : default number of entries (power of two, >= 4)
//   clog2()       : pointer width for a given depth
package inst_fifo_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  except;
    } fifo_entry_t;

    localparam int DEFAULT_DEPTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < n; i++) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/inst_fifo_if.sv
// inst_fifo_if: fetch-write, issue-pop and read-view signals of the instruction buffer.
//   master modport : fetch/issue side (drives flush, writes and pops; sees status and slots)
//   slave modport  : the buffer itself
//   flush, w_en1/2, w_pc1/2, w_inst1/2, w_except1/2 : write side
//   pop1, pop2                                      : issue side
//   fifo_full, fifo_empty, r_master_*, r_slave_*    : status and head/head+1 view
interface inst_fifo_if;

    logic        flush;
    logic        w_en1;
    logic        w_en2;
    logic [31:0] w_pc1;
    logic [31:0] w_pc2;
    logic [31:0] w_inst1;
    logic [31:0] w_inst2;
    logic [7:0]  w_except1;
    logic [7:0]  w_except2;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop1;
    logic        pop2;
    logic        r_master_valid;
    logic        r_slave_valid;
    logic [31:0] r_master_pc;
    logic [31:0] r_slave_pc;
    logic [31:0] r_master_inst;
    logic [31:0] r_slave_inst;
    logic [7:0]  r_master_except;
    logic [7:0]  r_slave_except;

    modport master (
        output flush, w_en1, w_en2, w_pc1, w_pc2, w_inst1, w_inst2, w_except1, w_except2, pop1, pop2,
        input  fifo_full, fifo_empty, r_master_valid, r_slave_valid, r_master_pc, r_slave_pc,
               r_master_inst, r_slave_inst, r_master_except, r_slave_except
    );

    modport slave (
        input  flush, w_en1, w_en2, w_pc1, w_pc2, w_inst1, w_inst2, w_except1, w_except2, pop1, pop2,
        output fifo_full, fifo_empty, r_master_valid, r_slave_valid, r_master_pc, r_slave_pc,
               r_master_inst, r_slave_inst, r_master_except, r_slave_except
    );

endinterface

// File: rtl/inst_fifo_mem.sv
// inst_fifo_mem: DEPTH x fifo_entry_t register array, two write ports and two async read ports.
//   clk          : clock
//   i_we0/i_we1  : write enables for entry[i_waddr] and entry[i_waddr+1]
//   i_waddr      : tail pointer
//   i_wd0/i_wd1  : write data
//   i_raddr      : head pointer
//   o_rd0/o_rd1  : entry[i_raddr] and entry[i_raddr+1]
module inst_fifo_mem
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PW = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we0,
    input  logic          i_we1,
    input  logic [PW-1:0] i_waddr,
    input  fifo_entry_t   i_wd0,
    input  fifo_entry_t   i_wd1,
    input  logic [PW-1:0] i_raddr,
    output fifo_entry_t   o_rd0,
    output fifo_entry_t   o_rd1
);

    fifo_entry_t   r_mem [DEPTH];
    logic [PW-1:0] w_waddr1;
    logic [PW-1:0] w_raddr1;

    assign w_waddr1 = i_waddr + PW'(1);
    assign w_raddr1 = i_raddr + PW'(1);

    // Storage needs no reset: entries are only observed through valid slots.
    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_waddr] <= i_wd0;
        if (i_we1) r_mem[w_waddr1] <= i_wd1;
    end

    assign o_rd0 = r_mem[i_raddr];
    assign o_rd1 = r_mem[w_raddr1];

endmodule

// File: rtl/inst_fifo.sv
// inst_fifo: dual-issue instruction decoupling buffer between fetch and decode/issue.
//   clk : clock, rising edge
//   rst : synchronous reset, active-low
//   bus : inst_fifo_if.slave (writes, pops, flush, status, master/slave read slots)
// Optional feature: define INST_FIFO_BYPASS_EN to append this cycle's accepted writes to
// the read view (0-cycle latency); otherwise written entries appear one cycle later.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic        clk,
    input logic        rst,
    inst_fifo_if.slave bus
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] FULL_LIM = (PW+1)'(DEPTH - 2);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          w_full;
    logic          w_acc;
    logic [1:0]    w_wn;
    logic [1:0]    w_pn;
    logic [1:0]    w_cons;
    logic [1:0]    w_hadv;
    logic [1:0]    w_store;
    logic [PW:0]   w_avail;
    logic          w_mv;
    logic          w_sv;
    fifo_entry_t   w_s1;
    fifo_entry_t   w_s2;
    fifo_entry_t   w_rd0;
    fifo_entry_t   w_rd1;
    fifo_entry_t   w_m;
    fifo_entry_t   w_s;
    fifo_entry_t   w_d0;
    fifo_entry_t   w_mo;
    fifo_entry_t   w_so;

    assign w_s1 = {bus.w_pc1, bus.w_inst1, bus.w_except1};
    assign w_s2 = {bus.w_pc2, bus.w_inst2, bus.w_except2};

    // Gating by rst keeps bypassed writes off the outputs during reset.
    assign w_full = r_count > FULL_LIM;
    assign w_acc  = rst && !bus.flush && !w_full && bus.w_en1;
    assign w_wn   = w_acc ? (bus.w_en2 ? 2'd2 : 2'd1) : 2'd0;

`ifdef INST_FIFO_BYPASS_EN
    // View = stored entries followed by this cycle's accepted write slots.
    assign w_avail = r_count + (PW+1)'(w_wn);
    assign w_m     = (r_count != '0) ? w_rd0 : w_s1;
    assign w_s     = (r_count[PW:1] != '0) ? w_rd1 : (r_count == (PW+1)'(1)) ? w_s1 : w_s2;
`else
    assign w_avail = r_count;
    assign w_m     = w_rd0;
    assign w_s     = w_rd1;
`endif

    assign w_mv = rst && (w_avail != '0);
    assign w_sv = rst && (w_avail[PW:1] != '0);
    assign w_pn = (bus.pop1 && w_mv) ? ((bus.pop2 && w_sv) ? 2'd2 : 2'd1) : 2'd0;

    // Pops beyond the stored count consume bypassed write slots; those are never stored,
    // so the head only moves over stored entries and the tail only over kept writes.
    assign w_cons  = ({{(PW-1){1'b0}}, w_pn} > r_count) ? w_pn - r_count[1:0] : 2'd0;
    assign w_hadv  = w_pn - w_cons;
    assign w_store = w_wn - w_cons;
    assign w_d0    = (w_cons == 2'd0) ? w_s1 : w_s2;

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_hadv);
            r_tail  <= r_tail + PW'(w_store);
            r_count <= r_count + (PW+1)'(w_wn) - (PW+1)'(w_pn);
        end
    end

    inst_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we0   (w_store != 2'd0),
        .i_we1   (w_store == 2'd2),
        .i_waddr (r_tail),
        .i_wd0   (w_d0),
        .i_wd1   (w_s2),
        .i_raddr (r_head),
        .o_rd0   (w_rd0),
        .o_rd1   (w_rd1)
    );

    assign w_mo = w_mv ? w_m : '0;
    assign w_so = w_sv ? w_s : '0;

    assign bus.fifo_full       = w_full;
    assign bus.fifo_empty      = (r_count == '0);
    assign bus.r_master_valid  = w_mv;
    assign bus.r_master_pc     = w_mo.pc;
    assign bus.r_master_inst   = w_mo.inst;
    assign bus.r_master_except = w_mo.except;
    assign bus.r_slave_valid   = w_sv;
    assign bus.r_slave_pc      = w_so.pc;
    assign bus.r_slave_inst    = w_so.inst;
    assign bus.r_slave_except  = w_so.except;

endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: scoreboard bench for inst_fifo; honours INST_FIFO_BYPASS_EN like the design.
module tb_inst_fifo;

    localparam int DEPTH = inst_fifo_pkg::DEFAULT_DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] nxt_pc;
    logic [71:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    inst_fifo_if bus();

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] ent(input logic [31:0] pc);
        return {pc, ~pc, pc[9:2]};
    endfunction

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check the view before the edge, then advance the model at the edge.
    task automatic step(input bit fl, input bit e1, input bit e2, input bit p1, input bit p2);
        logic [71:0] view[$];
        int          wn;
        int          pn;
        bus.flush     = fl;
        bus.w_en1     = e1;
        bus.w_en2     = e2;
        bus.w_pc1     = nxt_pc;
        bus.w_pc2     = nxt_pc + 32'd4;
        bus.w_inst1   = ~nxt_pc;
        bus.w_inst2   = ~(nxt_pc + 32'd4);
        bus.w_except1 = nxt_pc[9:2];
        bus.w_except2 = bus.w_pc2[9:2];
        bus.pop1      = p1;
        bus.pop2      = p2;
        wn = (rst && !fl && exp_q.size() <= DEPTH - 2 && e1) ? (e2 ? 2 : 1) : 0;
        view = exp_q;
`ifdef INST_FIFO_BYPASS_EN
        for (int i = 0; i < wn; i++) view.push_back(ent(nxt_pc + 32'(4 * i)));
`endif
        @(negedge clk);
        check("m_valid", 72'(bus.r_master_valid), 72'(view.size() >= 1));
        check("m_entry", {bus.r_master_pc, bus.r_master_inst, bus.r_master_except},
              view.size() >= 1 ? view[0] : 72'd0);
        check("s_valid", 72'(bus.r_slave_valid), 72'(view.size() >= 2));
        check("s_entry", {bus.r_slave_pc, bus.r_slave_inst, bus.r_slave_except},
              view.size() >= 2 ? view[1] : 72'd0);
        check("full", 72'(bus.fifo_full), 72'(exp_q.size() > DEPTH - 2));
        check("empty", 72'(bus.fifo_empty), 72'(exp_q.size() == 0));
        @(posedge clk);
        #1;
        pn = p1 ? (p2 ? 2 : 1) : 0;
        if (pn > view.size()) pn = view.size();
        for (int i = 0; i < pn; i++) void'(view.pop_front());
`ifndef INST_FIFO_BYPASS_EN
        for (int i = 0; i < wn; i++) view.push_back(ent(nxt_pc + 32'(4 * i)));
`endif
        if (!rst || fl) exp_q.delete();
        else exp_q = view;
        nxt_pc = nxt_pc + 32'(4 * wn);
    endtask

    initial begin
        nxt_pc = 32'h0;
        bus.flush = 1'b0;
        bus.w_en1 = 1'b1;
        bus.w_en2 = 1'b0;
        bus.w_pc1 = '0;
        bus.w_pc2 = '0;
        bus.w_inst1 = '0;
        bus.w_inst2 = '0;
        bus.w_except1 = '0;
        bus.w_except2 = '0;
        bus.pop1 = 1'b0;
        bus.pop2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 1, 0, 0, 0);
        rst = 1'b1;
        nxt_pc = 32'hBFC00000;
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        nxt_pc = 32'h100;
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        nxt_pc = 32'h1000;
        repeat (8) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (20) step(0, 1, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (9) step(0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        nxt_pc = 32'h200;
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        repeat (300) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Dual-issue instruction decoupling buffer between the fetch stage and the decode/issue stage. It accepts up to two fetched instructions per cycle in program order and presents the oldest two as master and slave slots. Issue logic pops 0, 1 or 2 per cycle, and decode results then enter the ID/EX pipeline register. Its flush is driven by branch-redirect and exception logic.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- flush  in  1  discard all stored entries and this cycle's writes
- w_en1  in  1  write slot 1, the older instruction
- w_en2  in  1  write slot 2, the younger instruction; honoured only together with w_en1
- w_pc1, w_pc2  in  32  fetch PCs
- w_inst1, w_inst2  in  32  instruction words
- w_except1, w_except2  in  8  fetch-side exception vector
- fifo_full  out  1  high when count > DEPTH-2; all writes are ignored while high
- fifo_empty  out  1  high when count == 0
- pop1  in  1  master slot consumed
- pop2  in  1  slave slot consumed; honoured only together with pop1
- r_master_valid, r_slave_valid  out  1  slot holds an instruction
- r_master_pc, r_slave_pc  out  32  head and head+1 PC
- r_master_inst, r_slave_inst  out  32  head and head+1 instruction word
- r_master_except, r_slave_except  out  8  head and head+1 exception vector

## Operation
- Circular buffer with head pointer, tail pointer and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Write count: wn = 0 if fifo_full or flush. Otherwise wn = w_en1 + (w_en1 & w_en2).
- Slot 1 is stored at the tail and slot 2 at tail+1. The tail advances by wn.
- Pop count: pn = pop1 + (pop1 & pop2), clamped to the number of visible valid slots. Popping an invalid slot has no effect.
- The head advances by pn. Next count = count + wn − pn.
- Read view, without bypass: r_master shows entry[head] and is valid when count ≥ 1. r_slave shows entry[head+1] and is valid when count ≥ 2.
- Data outputs are forced to 0 whenever their slot's valid bit is low.
- Flush: head, tail and count go to 0 and incoming writes are dropped. Pops in the same cycle are irrelevant.
- Reset: head, tail and count go to 0, all valid outputs are 0, all data outputs are 0, fifo_empty is 1 and fifo_full is 0.

## Timing
- Without bypass, a written entry is visible on the read outputs the cycle after the write: 1-cycle latency.
- A pop takes effect at the next edge. The read outputs show the new head in the following cycle.
- Simultaneous write and pop is allowed at any occupancy. fifo_full is evaluated on the pre-edge count only.
- fifo_full and fifo_empty are registered-state functions of count, not of the current cycle's inputs.
- Precedence: rst, then flush, then normal operation.

## Configuration
- INST_FIFO_BYPASS_EN defined:
  - The read view is the stored entries followed by this cycle's accepted write slots, so data written into an empty FIFO is visible combinationally (0-cycle latency).
  - Pops may consume bypassed slots. Only unconsumed write slots are stored, and count follows the same formula.
  - The bypass is disabled in any cycle where flush is high.
- INST_FIFO_BYPASS_EN undefined: the read view is stored entries only, with 1-cycle latency as described above.

## Structure
- Package inst_fifo_pkg holds:
  - fifo_entry_t, a struct of pc[31:0], inst[31:0] and except[7:0];
  - default DEPTH;
  - pointer-width function clog2(DEPTH).
- Sub-module inst_fifo_mem: a DEPTH × fifo_entry_t register array with two write ports and two asynchronous read ports. Write ports are indexed tail and tail+1; read ports are indexed head and head+1.
- Pointer, count and bypass-mux logic live in inst_fifo.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with w_en1=1 → count 0, fifo_empty=1, all r_* = 0. Release and write pc 0xBFC00000 / 0xBFC00004 → next cycle master pc 0xBFC00000 and slave pc 0xBFC00004, both valid.
- **Single-pop ordering:** write four instructions with pcs 0x100, 0x104, 0x108, 0x10C, then pop1 only for 4 cycles → master pc steps 0x100, 0x104, 0x108, 0x10C, then fifo_empty=1.
- **Full and wrap, DEPTH=16:** write 2 per cycle for 8 cycles → fifo_full=1 at count 15 or 16. A further write leaves count unchanged. Pop2 with a simultaneous write for 20 cycles → pcs stay strictly sequential across the pointer wrap.
- **Over-pop:** count=1, assert pop1 and pop2 → count 0 and head advances by 1 only. Pop1 at count 0 → no change.
- **Flush:** count=6, assert flush with w_en1, w_en2 and pop2 → next cycle count 0, all valid outputs 0, and neither write is stored.
- **Bypass (with INST_FIFO_BYPASS_EN):** empty FIFO, write pc 0x200 and 0x204 with pop1 → master pc 0x200 is visible in the same cycle, and the next cycle master pc is 0x204 with count 1. Without the macro, the same stimulus gives no valid output in the write cycle.
